// File: rtl/fp_issue_pkg.sv
// fp_issue_pkg: shared FP types used by the issue/credit block and its result buffer.
`default_nettype none

package fp_issue_pkg;

  typedef logic [31:0] Float32;

  typedef struct packed {
    logic   op;
    Float32 a;
    Float32 b;
  } FpIssueReq;

endpackage

`default_nettype wire

// File: rtl/fp_res_fifo.sv
// fp_res_fifo: result buffer for the FP pipeline; drops and flags pushes that find it full.
`default_nettype none

module fp_res_fifo
  import fp_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  Float32        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign empty_o    = (occ_q == '0);
  assign full_o     = (occ_q == FULL_OCC);
  assign overflow_o = ovf_q;
  assign data_o     = mem_q[rptr_q];

  // A full buffer still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      occ_d = occ_q + OW'(1);
    else if (!do_push && do_pop) occ_d = occ_q - OW'(1);
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/fp_issue.sv
// fp_issue: credit-based issue of add/sub requests into an FP pipeline with an in-order result buffer.
`default_nettype none

module fp_issue
  import fp_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        fp_flag_i,
  output logic        fp_op,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  input  logic        fp_flag_o,
  input  logic [31:0] fp_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_param
    $error("fp_issue: DEPTH must be a power of two in 2..16 and LAT at least 1");
  end

  FpIssueReq     req;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          issue, pop, full, empty;

  assign req       = '{op: in_op, a: in_a, b: in_b};
  assign fp_op     = req.op;
  assign fp_a      = req.a;
  assign fp_b      = req.b;

  // Credits cover both in-flight ops and buffered results, so the buffer can never be overrun.
  assign in_ready  = (cnt_q < DEPTH_C);
  assign issue     = in_valid & in_ready;
  assign fp_flag_i = issue;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  fp_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fp_flag_o),
    .data_i    (fp_c),
    .pop_i     (pop),
    .data_o    (out_c),
    .full_o    (full),
    .empty_o   (empty),
    .overflow_o(overflow)
  );

  a_full_has_credits: assert property (@(posedge clk) disable iff (rst) full |-> (cnt_q == DEPTH_C));

endmodule

`default_nettype wire

// File: tb/tb_fp_issue.sv
// tb_fp_issue: drives fp_issue with a behavioural LAT-cycle FP adder and checks against a result queue model.
`timescale 1ns/1ps
`default_nettype none

module tb_fp_issue;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_op = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, fp_flag_i, fp_op, fp_flag_o, out_valid, overflow;
  logic [31:0] fp_a, fp_b, fp_c, out_c;

  logic        man_mode = 1'b0;
  logic        man_flag = 1'b0;
  logic [31:0] man_c = '0;
  logic [LAT-1:0] pv;
  logic [31:0]    pc [LAT];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mcnt = 0;

  typedef struct {
    logic [31:0] c;
    int          rdy;
  } exp_t;
  exp_t mq[$];

  always #5 clk = ~clk;

  fp_issue #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .fp_flag_i(fp_flag_i), .fp_op(fp_op), .fp_a(fp_a),
    .fp_b(fp_b), .fp_flag_o(fp_flag_o), .fp_c(fp_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .overflow(overflow)
  );

  // Float32 <-> real via the double bit layout; operands are small integers so every result is exact.
  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) return 0.0;
    d = {f[31], 3'b000, f[30:23], f[22:0], 29'd0};
    d[62:52] = d[62:52] + 11'd896;
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic op, logic [31:0] a, logic [31:0] b);
    return r2f(op ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2f(real'($urandom_range(0, 1000)));
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].rdy <= cyc);
  endfunction

  // Stand-in FP add pipeline; the bench can take over its output pins for fault injection.
  assign fp_flag_o = man_mode ? man_flag : pv[LAT-1];
  assign fp_c      = man_mode ? man_c    : pc[LAT-1];

  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], fp_flag_i};
    pc[0] <= fadd(fp_op, fp_a, fp_b);
    for (int i = 1; i < LAT; i++) pc[i] <= pc[i-1];
  end

  // Advance one clock and update the model: inputs were set after the previous negedge.
  task automatic tick();
    bit iss, pp;
    logic [31:0] r;
    iss = in_valid && (mcnt < DEPTH);
    pp  = out_ready && m_valid();
    r   = fadd(in_op, in_a, in_b);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (iss) mq.push_back('{r, cyc + LAT + 1});
      mcnt = mcnt + int'(iss) - int'(pp);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_op();
    in_op = 1'($urandom_range(0, 1));
    in_a  = rnd_f();
    in_b  = rnd_f();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    tick();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_chk++; if (fp_flag_i !== 1'b1) begin n_fail++; $display("FAIL reset_flag_follows_hi got=%b want=1", fp_flag_i); end
    in_valid = 1'b0;
    #1;
    n_chk++; if (fp_flag_i !== 1'b0) begin n_fail++; $display("FAIL reset_flag_follows_lo got=%b want=0", fp_flag_i); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; out_ready = 1'b0;
    #1;
    n_chk++; if (fp_flag_i !== 1'b1 || fp_a !== 32'h3F80_0000 || fp_b !== 32'h4000_0000 || fp_op !== 1'b0) begin
      n_fail++; $display("FAIL single_passthru flag=%b op=%b a=%h b=%h want 1 0 3f800000 40000000", fp_flag_i, fp_op, fp_a, fp_b);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_chk++; if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL single_latency cycle=%0d out_valid=%b want=%b", k, out_valid, (k == 3)); end
      if (k < 3) tick();
    end
    n_chk++; if (out_c !== 32'h4040_0000) begin n_fail++; $display("FAIL single_result got=%h want=40400000", out_c); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_after_pop out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    n_chk++; if (u_dut.cnt_q !== '0) begin n_fail++; $display("FAIL single_cnt got=%0d want=0", u_dut.cnt_q); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int pops = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; set_op();
      #1;
      n_chk++; if (in_ready !== (mcnt < DEPTH)) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b want=%b", k, in_ready, (mcnt < DEPTH)); end
      if (fp_flag_i === 1'b1) acc++;
      tick();
    end
    in_valid = 1'b0;
    n_chk++; if (acc != DEPTH) begin n_fail++; $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stalled in_ready=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 12 && pops < DEPTH; k++) begin
      n_chk++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL bp_out_valid got=%b want=%b", out_valid, m_valid()); end
      if (m_valid()) begin
        n_chk++; if (out_c !== mq[0].c) begin n_fail++; $display("FAIL bp_order got=%h want=%h", out_c, mq[0].c); end
        pops++;
      end
      tick();
      if (pops == 1) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got=%b want=1", in_ready); end
      end
    end
    n_chk++; if (pops != DEPTH) begin n_fail++; $display("FAIL bp_pops got=%0d want=%0d", pops, DEPTH); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int issued = 0;
    int pops = 0;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && pops < 16; k++) begin
      in_valid = (issued < 16);
      set_op();
      #1;
      if (issued < 16) begin
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k=%0d got=%b want=1", k, in_ready); end
      end
      n_chk++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL stream_out_valid k=%0d got=%b want=%b", k, out_valid, m_valid()); end
      if (m_valid()) begin
        n_chk++; if (out_c !== mq[0].c) begin n_fail++; $display("FAIL stream_data k=%0d got=%h want=%h", k, out_c, mq[0].c); end
        if (first < 0) first = cyc;
        last = cyc;
        pops++;
      end
      if (in_valid && mcnt < DEPTH) issued++;
      tick();
    end
    in_valid = 1'b0;
    n_chk++; if (pops != 16 || last - first != 15) begin n_fail++; $display("FAIL stream_rate pops=%0d span=%0d want 16 15", pops, last - first); end
  endtask

  task automatic test_full_issue_pop();
    out_ready = 1'b0; in_valid = 1'b1; set_op();
    for (int k = 0; k < 20 && !(mcnt == DEPTH && m_valid()); k++) begin
      set_op();
      tick();
    end
    n_chk++; if (!(mcnt == DEPTH && m_valid())) begin n_fail++; $display("FAIL fip_fill timeout mcnt=%0d", mcnt); end
    out_ready = 1'b1; in_valid = 1'b1; set_op();
    #1;
    n_chk++; if (in_ready !== 1'b0 || fp_flag_i !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL fip_full in_ready=%b flag=%b out_valid=%b want 0 0 1", in_ready, fp_flag_i, out_valid);
    end
    tick();
    n_chk++; if (in_ready !== 1'b1 || fp_flag_i !== 1'b1) begin n_fail++; $display("FAIL fip_next in_ready=%b flag=%b want 1 1", in_ready, fp_flag_i); end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      n_chk++; if (u_dut.cnt_q > 3'(DEPTH)) begin n_fail++; $display("FAIL fip_cnt_bound got=%0d want<=%0d", u_dut.cnt_q, DEPTH); end
      if (m_valid()) begin
        n_chk++; if (out_c !== mq[0].c) begin n_fail++; $display("FAIL fip_data got=%h want=%h", out_c, mq[0].c); end
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin set_op(); tick(); end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rstmid out_valid=%b in_ready=%b overflow=%b want 0 1 0", out_valid, in_ready, overflow);
    end
    for (int k = 0; k < 4; k++) tick();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin set_op(); tick(); end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && mq[DEPTH-1].rdy > cyc; k++) tick();
    n_chk++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pre overflow=%b out_valid=%b want 0 1", overflow, out_valid); end
    man_mode = 1'b1; man_flag = 1'b1; man_c = 32'hDEAD_BEEF;
    tick();
    man_flag = 1'b0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", overflow); end
    tick(); tick();
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    man_mode = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      n_chk++; if (out_valid !== 1'b1 || out_c !== mq[0].c) begin n_fail++; $display("FAIL ovf_contents k=%0d valid=%b got=%h want=%h", k, out_valid, out_c, mq[0].c); end
      tick();
    end
    n_chk++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drained out_valid=%b overflow=%b want 0 1", out_valid, overflow); end
    out_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_op();
      #1;
      n_chk++; if (in_ready !== (mcnt < DEPTH) || fp_flag_i !== (in_valid && mcnt < DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready k=%0d in_ready=%b flag=%b mcnt=%0d", k, in_ready, fp_flag_i, mcnt);
      end
      n_chk++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_out_valid k=%0d got=%b want=%b", k, out_valid, m_valid()); end
      if (m_valid()) begin
        n_chk++; if (out_c !== mq[0].c) begin n_fail++; $display("FAIL rnd_data k=%0d got=%h want=%h", k, out_c, mq[0].c); end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      if (m_valid()) begin
        n_chk++; if (out_c !== mq[0].c) begin n_fail++; $display("FAIL rnd_drain got=%h want=%h", out_c, mq[0].c); end
      end
      tick();
    end
    n_chk++; if (mq.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rnd_end left=%0d out_valid=%b overflow=%b", mq.size(), out_valid, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_full_issue_pop();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
